// File: rtl/sys_types_pkg.sv
// Shared types and helpers for the output drain coordinator.
package sys_types;

  localparam int unsigned SYS_MAX_N  = 16;
  localparam int unsigned SYS_N_BITS = $clog2(SYS_MAX_N + 1);

  typedef struct packed {
    logic [SYS_N_BITS-1:0] row;
    logic [SYS_N_BITS-1:0] col;
  } pe_coord_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lowest_set_arbiter.sv
// Priority encoder: reports the index of the lowest set request bit.
module lowest_set_arbiter #(
  parameter int WIDTH = 16,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    // Scan high to low so the lowest set bit is written last.
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (req_i[i-1]) idx_o = IW'(i - 1);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/output_drain_coordinator.sv
// Wavefront tracker for an output-stationary systolic array, with per-PE
// pending store and a single valid/ready drain slot.
module output_drain_coordinator
  import sys_types::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int MAX_N          = 16,
  parameter int MACS_PER_CYCLE = 4,
  parameter int N_BITS         = $clog2(MAX_N + 1),
  parameter int CT_BITS        = $clog2((MAX_N + MACS_PER_CYCLE - 1) / MACS_PER_CYCLE + 1),
  parameter int IDX_BITS       = $clog2(ROWS * COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_BITS-1:0]                mat_size,
  input  logic                             input_valid,
  input  logic                             stall,
  input  logic [N_BITS-1:0]                pos_row,
  input  logic [N_BITS-1:0]                pos_col,
  output logic [ROWS*COLS-1:0]             out_valid,
  output logic [ROWS*COLS-1:0][N_BITS-1:0] out_row,
  output logic [ROWS*COLS-1:0][N_BITS-1:0] out_col,
  output logic                             drain_valid,
  input  logic                             drain_ready,
  output logic [IDX_BITS-1:0]              drain_pe_idx,
  output logic [N_BITS-1:0]                drain_row,
  output logic [N_BITS-1:0]                drain_col,
  output logic [IDX_BITS:0]                pending_cnt,
  output logic                             busy,
  output logic                             overflow,
  output logic                             inject_err
);

  localparam int unsigned NPE = ROWS * COLS;

  function automatic int unsigned wave_src(input int unsigned k);
    return (k % COLS == 0) ? k - COLS : k - 1;
  endfunction

  logic [NPE-1:0]     active_q, active_d;
  logic [NPE-1:0]     start_q, start_d;
  logic [CT_BITS-1:0] cnt_q [NPE];
  logic [CT_BITS-1:0] cnt_d [NPE];
  logic [CT_BITS-1:0] c_q [NPE];
  logic [CT_BITS-1:0] c_d [NPE];
  logic [N_BITS-1:0]  base_row_q [NPE];
  logic [N_BITS-1:0]  base_row_d [NPE];
  logic [N_BITS-1:0]  base_col_q [NPE];
  logic [N_BITS-1:0]  base_col_d [NPE];
  logic [N_BITS-1:0]  size_q [NPE];
  logic [N_BITS-1:0]  size_d [NPE];
  logic               inject_err_q, inject_err_d;

  logic [31:0]        inj_c_raw;
  logic [CT_BITS-1:0] inj_c;
  logic               pe0_free;

  assign inj_c_raw = ceil_div(32'(mat_size), 32'(MACS_PER_CYCLE));
  assign inj_c     = (inj_c_raw == 32'd0) ? CT_BITS'(1) : CT_BITS'(inj_c_raw);
  assign pe0_free  = !active_q[0] || (cnt_q[0] == '0);

  always_comb begin
    active_d     = active_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    base_row_d   = base_row_q;
    base_col_d   = base_col_q;
    size_d       = size_q;
    inject_err_d = inject_err_q;
    if (!stall) begin
      start_d = '0;
      for (int unsigned k = 0; k < NPE; k++) begin
        if (active_q[k]) begin
          if (cnt_q[k] != '0) cnt_d[k] = cnt_q[k] - 1'b1;
          else                active_d[k] = 1'b0;
        end
      end
      if (input_valid) begin
        if (pe0_free) begin
          active_d[0]   = 1'b1;
          start_d[0]    = 1'b1;
          cnt_d[0]      = inj_c - 1'b1;
          c_d[0]        = inj_c;
          base_row_d[0] = pos_row;
          base_col_d[0] = pos_col;
          size_d[0]     = mat_size;
        end else begin
          inject_err_d = 1'b1;
        end
      end
      // Reloads are applied after the countdown so a reload wins over retirement.
      for (int unsigned k = 1; k < NPE; k++) begin
        if (start_q[wave_src(k)]) begin
          active_d[k]   = 1'b1;
          start_d[k]    = 1'b1;
          cnt_d[k]      = c_q[wave_src(k)] - 1'b1;
          c_d[k]        = c_q[wave_src(k)];
          base_row_d[k] = base_row_q[wave_src(k)];
          base_col_d[k] = base_col_q[wave_src(k)];
          size_d[k]     = size_q[wave_src(k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      start_q      <= '0;
      inject_err_q <= 1'b0;
      for (int unsigned k = 0; k < NPE; k++) begin
        cnt_q[k]      <= '0;
        c_q[k]        <= '0;
        base_row_q[k] <= '0;
        base_col_q[k] <= '0;
        size_q[k]     <= '0;
      end
    end else begin
      active_q     <= active_d;
      start_q      <= start_d;
      inject_err_q <= inject_err_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      base_row_q   <= base_row_d;
      base_col_q   <= base_col_d;
      size_q       <= size_d;
    end
  end

  logic [N_BITS-1:0] row_abs [NPE];
  logic [N_BITS-1:0] col_abs [NPE];

  always_comb begin
    row_abs   = '{default: '0};
    col_abs   = '{default: '0};
    out_valid = '0;
    out_row   = '0;
    out_col   = '0;
    for (int unsigned k = 0; k < NPE; k++) begin
      row_abs[k]   = base_row_q[k] + N_BITS'(k / COLS);
      col_abs[k]   = base_col_q[k] + N_BITS'(k % COLS);
      out_row[k]   = active_q[k] ? row_abs[k] : '0;
      out_col[k]   = active_q[k] ? col_abs[k] : '0;
      out_valid[k] = active_q[k] && (cnt_q[k] == '0) && !stall &&
                     (row_abs[k] < size_q[k]) && (col_abs[k] < size_q[k]);
    end
  end

  logic [NPE-1:0]      pend_q, pend_d, pend_clr;
  logic [N_BITS-1:0]   pend_row_q [NPE];
  logic [N_BITS-1:0]   pend_row_d [NPE];
  logic [N_BITS-1:0]   pend_col_q [NPE];
  logic [N_BITS-1:0]   pend_col_d [NPE];
  logic                overflow_q, overflow_d;
  logic [IDX_BITS-1:0] arb_idx;
  logic                arb_any;
  logic                slot_full_q, slot_full_d;
  logic [IDX_BITS-1:0] slot_idx_q, slot_idx_d;
  logic [N_BITS-1:0]   slot_row_q, slot_row_d;
  logic [N_BITS-1:0]   slot_col_q, slot_col_d;
  logic                slot_take, slot_load;

  lowest_set_arbiter #(
    .WIDTH (NPE)
  ) u_arb (
    .req_i (pend_q),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign slot_take = slot_full_q && drain_ready;
  assign slot_load = arb_any && (!slot_full_q || slot_take);

  always_comb begin
    pend_clr = '0;
    if (slot_load) pend_clr[arb_idx] = 1'b1;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    pend_col_d = pend_col_q;
    overflow_d = overflow_q;
    for (int unsigned k = 0; k < NPE; k++) begin
      pend_d[k] = (pend_q[k] && !pend_clr[k]) || out_valid[k];
      if (out_valid[k]) begin
        if (pend_q[k] && !pend_clr[k]) begin
          overflow_d = 1'b1;
        end else begin
          pend_row_d[k] = row_abs[k];
          pend_col_d[k] = col_abs[k];
        end
      end
    end
    slot_full_d = slot_full_q;
    slot_idx_d  = slot_idx_q;
    slot_row_d  = slot_row_q;
    slot_col_d  = slot_col_q;
    if (slot_load) begin
      slot_full_d = 1'b1;
      slot_idx_d  = arb_idx;
      slot_row_d  = pend_row_q[arb_idx];
      slot_col_d  = pend_col_q[arb_idx];
    end else if (slot_take) begin
      slot_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      overflow_q  <= 1'b0;
      slot_full_q <= 1'b0;
      slot_idx_q  <= '0;
      slot_row_q  <= '0;
      slot_col_q  <= '0;
      for (int unsigned k = 0; k < NPE; k++) begin
        pend_row_q[k] <= '0;
        pend_col_q[k] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      pend_row_q  <= pend_row_d;
      pend_col_q  <= pend_col_d;
      overflow_q  <= overflow_d;
      slot_full_q <= slot_full_d;
      slot_idx_q  <= slot_idx_d;
      slot_row_q  <= slot_row_d;
      slot_col_q  <= slot_col_d;
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int unsigned k = 0; k < NPE; k++) begin
      pending_cnt = pending_cnt + (IDX_BITS+1)'(pend_q[k]);
    end
  end

  assign drain_valid  = slot_full_q;
  assign drain_pe_idx = slot_idx_q;
  assign drain_row    = slot_row_q;
  assign drain_col    = slot_col_q;
  assign busy         = (|active_q) || (|pend_q) || slot_full_q;
  assign overflow     = overflow_q;
  assign inject_err   = inject_err_q;

endmodule

// File: tb/tb_output_drain_coordinator.sv
// Directed bench for output_drain_coordinator (4x4 array, MAX_N=16, 4 MACs/cycle).
module tb_output_drain_coordinator;
  import sys_types::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NPE  = ROWS * COLS;
  localparam int NB   = 5;
  localparam int IB   = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NB-1:0]           mat_size;
  logic                    input_valid;
  logic                    stall;
  logic [NB-1:0]           pos_row;
  logic [NB-1:0]           pos_col;
  logic [NPE-1:0]          out_valid;
  logic [NPE-1:0][NB-1:0]  out_row;
  logic [NPE-1:0][NB-1:0]  out_col;
  logic                    drain_valid;
  logic                    drain_ready;
  logic [IB-1:0]           drain_pe_idx;
  logic [NB-1:0]           drain_row;
  logic [NB-1:0]           drain_col;
  logic [IB:0]             pending_cnt;
  logic                    busy;
  logic                    overflow;
  logic                    inject_err;

  always #5 clk = ~clk;

  output_drain_coordinator #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .MAX_N          (16),
    .MACS_PER_CYCLE (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mat_size     (mat_size),
    .input_valid  (input_valid),
    .stall        (stall),
    .pos_row      (pos_row),
    .pos_col      (pos_col),
    .out_valid    (out_valid),
    .out_row      (out_row),
    .out_col      (out_col),
    .drain_valid  (drain_valid),
    .drain_ready  (drain_ready),
    .drain_pe_idx (drain_pe_idx),
    .drain_row    (drain_row),
    .drain_col    (drain_col),
    .pending_cnt  (pending_cnt),
    .busy         (busy),
    .overflow     (overflow),
    .inject_err   (inject_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int ov_cnt [NPE];
  int ov_cyc [NPE];
  int ov_row [NPE];
  int ov_col [NPE];
  int bt_cnt [NPE];
  int bt_row [NPE];
  int bt_col [NPE];
  int bt_seq [$];
  int last_beat;
  int busy_fall;
  bit busy_seen;

  task automatic clear_mon();
    for (int k = 0; k < NPE; k++) begin
      ov_cnt[k] = 0; ov_cyc[k] = -1; ov_row[k] = -1; ov_col[k] = -1;
      bt_cnt[k] = 0; bt_row[k] = -1; bt_col[k] = -1;
    end
    bt_seq.delete();
    last_beat = -1;
    busy_fall = -1;
    busy_seen = 1'b0;
  endtask

  // Drive the inputs for edge t, then record what the design presents before that edge.
  task automatic cycle(input int t, input logic iv, input logic st, input logic dr,
                       input logic rst, input logic [NB-1:0] ms,
                       input logic [NB-1:0] pr, input logic [NB-1:0] pc);
    @(posedge clk);
    #2;
    input_valid = iv; stall = st; drain_ready = dr; reset = rst;
    mat_size = ms; pos_row = pr; pos_col = pc;
    @(negedge clk);
    for (int k = 0; k < NPE; k++) begin
      if (out_valid[k]) begin
        ov_cnt[k]++;
        ov_cyc[k] = t;
        ov_row[k] = int'(out_row[k]);
        ov_col[k] = int'(out_col[k]);
      end
    end
    if (drain_valid && drain_ready) begin
      bt_cnt[drain_pe_idx]++;
      bt_row[drain_pe_idx] = int'(drain_row);
      bt_col[drain_pe_idx] = int'(drain_col);
      bt_seq.push_back(int'(drain_pe_idx));
      last_beat = t;
    end
    if (busy) busy_seen = 1'b1;
    else if (busy_seen && busy_fall < 0) busy_fall = t;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), 0);
    chk({tag, "_coords"}, 32'((out_row != '0) || (out_col != '0)), 0);
    chk({tag, "_dvalid"}, 32'(drain_valid), 0);
    chk({tag, "_dpay"}, 32'((drain_pe_idx != '0) || (drain_row != '0) || (drain_col != '0)), 0);
    chk({tag, "_pend"}, 32'(pending_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_ierr"}, 32'(inject_err), 0);
  endtask

  // Expected completion: PE(i,j) reports at cycle i+j+C+stalls when base+offset < N.
  task automatic chk_block(input string tag, input int ms, input int pr, input int pc,
                           input int c, input int delay);
    int exp_n = 0;
    pe_coord_t e;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        int k = i * COLS + j;
        bit in_rng = (pr + i < ms) && (pc + j < ms);
        e.row = NB'(pr + i);
        e.col = NB'(pc + j);
        chk($sformatf("%s_ovcnt%0d", tag, k), ov_cnt[k], in_rng ? 1 : 0);
        chk($sformatf("%s_btcnt%0d", tag, k), bt_cnt[k], in_rng ? 1 : 0);
        if (in_rng) begin
          exp_n++;
          chk($sformatf("%s_cyc%0d", tag, k), ov_cyc[k], i + j + c + delay);
          chk($sformatf("%s_row%0d", tag, k), ov_row[k], 32'(e.row));
          chk($sformatf("%s_col%0d", tag, k), ov_col[k], 32'(e.col));
          chk($sformatf("%s_btrow%0d", tag, k), bt_row[k], 32'(e.row));
          chk($sformatf("%s_btcol%0d", tag, k), bt_col[k], 32'(e.col));
        end
      end
    end
    chk({tag, "_beats"}, bt_seq.size(), exp_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq [4];
    int tot;
    exp_seq = '{0, 1, 4, 5};
    reset = 1'b1; input_valid = 1'b0; stall = 1'b0; drain_ready = 1'b1;
    mat_size = '0; pos_row = '0; pos_col = '0;
    clear_mon();

    for (int t = 0; t < 3; t++) cycle(t, 0, 0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    chk_idle("reset");

    // Full 16x16 block at origin, C=4.
    clear_mon();
    for (int t = 0; t < 28; t++) cycle(t, t == 0, 0, 1, 0, 16, 0, 0);
    chk_block("s1", 16, 0, 0, 4, 0);
    chk("s1_pe15_cyc", ov_cyc[15], 10);
    chk("s1_pe9_row", ov_row[9], 2);
    chk("s1_pe9_col", ov_col[9], 1);
    chk("s1_last_beat", last_beat, 21);
    chk("s1_busy_fall", busy_fall, 22);
    chk("s1_pend_end", 32'(pending_cnt), 0);
    chk("s1_ierr", 32'(inject_err), 0);
    chk("s1_ovf", 32'(overflow), 0);

    // N=6 at (4,4): only the top-left 2x2 PEs are in range, C=2.
    clear_mon();
    for (int t = 0; t < 20; t++) cycle(t, t == 0, 0, 1, 0, 6, 4, 4);
    chk_block("s2", 6, 4, 4, 2, 0);
    for (int n = 0; n < 4; n++)
      chk($sformatf("s2_order%0d", n), (n < bt_seq.size()) ? bt_seq[n] : -1, exp_seq[n]);
    chk("s2_last_beat", last_beat, 7);

    // Stall during cycles 2-4 shifts every completion by three.
    clear_mon();
    for (int t = 0; t < 30; t++) cycle(t, t == 0, (t >= 2) && (t <= 4), 1, 0, 16, 0, 0);
    chk_block("s3", 16, 0, 0, 4, 3);
    chk("s3_pe15_cyc", ov_cyc[15], 13);

    // Reset in cycle 6 discards everything in flight.
    clear_mon();
    for (int t = 0; t < 16; t++) begin
      cycle(t, t == 0, 0, 1, t == 6, 16, 0, 0);
      if (t == 6) begin
        chk("s6_pend_pre", 32'(pending_cnt), 2);
        chk("s6_busy_pre", 32'(busy), 1);
        chk("s6_dvalid_pre", 32'(drain_valid), 1);
      end
      if (t == 7) begin
        chk_idle("s6_post");
        clear_mon();
      end
    end
    tot = 0;
    for (int k = 0; k < NPE; k++) tot += ov_cnt[k];
    chk("s6_ov_after", tot, 0);
    chk("s6_beats_after", bt_seq.size(), 0);

    // N=4 (C=1) injected back-to-back with the drain blocked.
    for (int t = 0; t < 7; t++) begin
      cycle(t, t <= 2, 0, 0, 0, 4, (t == 0) ? 5'd1 : 5'd0, (t == 0) ? 5'd2 : 5'd0);
      if (t == 3) begin
        chk("s4_ovf_c3", 32'(overflow), 0);
        chk("s4_dvalid_c3", 32'(drain_valid), 1);
      end
      if (t == 4) chk("s4_ovf_c4", 32'(overflow), 1);
      if (t == 6) begin
        chk("s4_dvalid", 32'(drain_valid), 1);
        chk("s4_idx", 32'(drain_pe_idx), 0);
        chk("s4_row", 32'(drain_row), 1);
        chk("s4_col", 32'(drain_col), 2);
        chk("s4_ierr", 32'(inject_err), 0);
        chk("s4_ovf_sticky", 32'(overflow), 1);
      end
    end
    for (int t = 0; t < 2; t++) cycle(t, 0, 0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    chk_idle("s4_reset");

    // Second injection two cycles after the first is too early for C=4.
    clear_mon();
    for (int t = 0; t < 30; t++) begin
      cycle(t, (t == 0) || (t == 2), 0, 1, 0, 16, (t == 2) ? 5'd8 : 5'd0, (t == 2) ? 5'd8 : 5'd0);
      if (t == 2) chk("s5_ierr_c2", 32'(inject_err), 0);
      if (t == 3) chk("s5_ierr_c3", 32'(inject_err), 1);
    end
    chk_block("s5", 16, 0, 0, 4, 0);
    chk("s5_ierr_sticky", 32'(inject_err), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_drain_coordinator.md
# output_drain_coordinator

Next-generation output coordinator for the ROWS×COLS output-stationary systolic array. It tracks the diagonal wavefront of each injected output block per PE. It honours `stall`, and computes absolute, range-masked output coordinates with a configurable MACs-per-cycle rate. Completed PE results are queued and serialised onto a single valid/ready drain port that feeds the output buffer writer.

## Interface
- `ROWS`, 4, PE rows
- `COLS`, 4, PE columns
- `MAX_N`, 16, max matrix dimension
- `MACS_PER_CYCLE`, 4, MACs each PE retires per cycle
- `N_BITS`, $clog2(MAX_N+1), size/coordinate width
- `CT_BITS`, $clog2((MAX_N+MACS_PER_CYCLE-1)/MACS_PER_CYCLE+1), per-PE countdown width
- `IDX_BITS`, $clog2(ROWS*COLS), flat PE index width (index = i*COLS+j)

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `mat_size` in N_BITS: N, sampled with `input_valid`.
- `input_valid` in 1: inject new block at PE(0,0).
- `stall` in 1: freeze array-side tracking.
- `pos_row`, `pos_col` in N_BITS: block base coordinates.
- `out_valid` out [ROWS*COLS]×1: per-PE completion pulse.
- `out_row`, `out_col` out [ROWS*COLS]×N_BITS: absolute coordinates.
- `drain_valid` out 1, `drain_ready` in 1: drain handshake.
- `drain_pe_idx` out IDX_BITS, `drain_row`/`drain_col` out N_BITS: drain payload.
- `pending_cnt` out IDX_BITS+1: number of set pending flags.
- `busy` out 1: any PE active, any pending, or slot full.
- `overflow`, `inject_err` out 1: sticky errors, cleared only by reset.

## Operation
- C = max(1, ceil(mat_size/MACS_PER_CYCLE)), computed at injection.
- Per PE: `active`, `cnt` (CT_BITS), `start` pulse, `base_row`/`base_col`, `C`.
- Injection: `input_valid` & !stall & PE(0,0) idle-or-finishing (inactive, or `cnt`==0) → PE(0,0) loads active=1, cnt=C-1, base, C, start=1. Otherwise: if !stall, set `inject_err` and drop the block; if stall, ignore silently.
- Propagation: `start` of PE(i,j-1) loads PE(i,j) next cycle. For column 0, `start` of PE(i-1,0) loads PE(i,0). `start` lasts one non-stalled cycle.
- Countdown: active & cnt≠0 → cnt−1. Active & cnt==0 → active=0, unless reloaded in the same cycle; reload wins.
- `out_row[k]` = base_row+i and `out_col[k]` = base_col+j, computed N_BITS wide.
- `out_valid[k]` = active & cnt==0 & !stall & out_row<mat_size & out_col<mat_size of that block. Out-of-range PEs count down but never report.
- Stall: all active/cnt/start/base state holds; `out_valid` all 0. The drain side keeps running.
- Pending store: `out_valid[k]` sets `pending[k]` and captures the row/col. If `pending[k]` is already set and not being cleared that cycle, the new entry is dropped and `overflow` is set.
- Output slot: loads from the lowest-index pending PE when the slot is empty or accepted this cycle. Load clears that pending flag. A set and a clear on the same index in the same cycle → set wins, no overflow.
- `drain_valid` = slot full. Payload stays stable until `drain_valid`&`drain_ready`.

## Timing
- Reset: all state 0; all outputs 0, including the sticky flags. Reset mid-operation discards all in-flight and pending entries; no `drain_valid` in the cycle after reset.
- Cycle 0 = edge that samples `input_valid`. With no stalls, `out_valid` of PE(i,j) is high in cycle i+j+C, for exactly one cycle.
- Each stalled cycle before completion delays all later events by 1.
- Drain latency: `out_valid` in cycle T → pending set at T+1 → `drain_valid` at T+2.
- Throughput: 1 drain beat per cycle with `drain_ready` held high.
- Legal injection spacing is C cycles. Spacing ≥C never sets `inject_err`.

## Structure
- Shared package (sys_types): `pe_coord_t` struct {row, col : N_BITS}, and a `ceil_div` constant function for C.
- Sub-module `lowest_set_arbiter #(WIDTH)`: priority encoder over `pending` giving index + any.
- The remaining logic stays flat: wavefront tracker, pending store, slot.

## Test plan
Configuration: ROWS=COLS=4, MAX_N=16, MACS_PER_CYCLE=4.
- mat_size=16, pos (0,0), `drain_ready`=1 → C=4; PE0 `out_valid` cycle 4, PE15 cycle 10; PE(2,1) reports row 2, col 1; exactly 16 drain beats, each index once; `busy` falls after the last beat.
- mat_size=6, pos (4,4) → C=2; only PEs 0,1,4,5 pulse, with coords (4,4),(4,5),(5,4),(5,5); 4 drain beats.
- mat_size=16, `stall` high in cycles 2–4 → every `out_valid` is 3 cycles later than the previous case (PE15 at 13); no beats lost.
- mat_size=4, injections at cycles 0,1,2, `drain_ready`=0 → `overflow`=1 at cycle 4; the slot holds PE0 with block-0 coordinates.
- mat_size=16, injections at cycles 0 and 2 → `inject_err`=1; only 16 completions.
- `reset` in cycle 6 of the first scenario → all outputs 0 from cycle 7; `pending_cnt`=0; no drain beats after.
